// File: rtl/mem_io_pkg.sv
// Shared constants for the HPS-to-fabric mailbox: Avalon word map,
// STATUS register bit positions and the sticky underflow bit.
package mem_io_pkg;

  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_CONTROL  = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_CHSEL    = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd4;

  localparam int unsigned CHSEL_W       = 4;
  localparam int unsigned UNDERFLOW_BIT = 31;

  // STATUS bit reporting input FIFO `ch` full
  function automatic int unsigned status_full_bit(input int unsigned ch);
    return 2 * ch;
  endfunction

  // STATUS bit reporting output FIFO `ch` non-empty
  function automatic int unsigned status_nonempty_bit(input int unsigned ch);
    return 2 * ch + 1;
  endfunction

endpackage

// File: rtl/mem_io_fifo.sv
// Single-clock count-based FIFO, no bypass.
// Ports: clk/rst_n (sync, active-low), push/wdata, pop, head_c (current head,
// zero when empty), full/empty (registered), count (registered occupancy).
// Pushes while full and pops while empty are ignored.
module mem_io_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;
  logic [CNT_W-1:0] count_nxt_c;

  always_comb begin
    do_push_c   = push & ~full;
    do_pop_c    = pop & ~empty;
    count_nxt_c = count + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
  end

  // Head gated to zero so an empty FIFO never exposes stale storage
  assign head_c = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset; it is only visible through the gated head
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt_c;
      full  <= (count_nxt_c == CNT_W'(DEPTH));
      empty <= (count_nxt_c == '0);
    end
  end

endmodule

// File: rtl/mem_io_mailbox.sv
// HPS-to-fabric mailbox: Avalon-MM slave exposing a control word and
// CHANNELS input/output streams, each buffered by a DEPTH-entry FIFO.
// Ports: clk_clk, reset_reset_n (sync, active-low); avs_* Avalon-MM slave
// (address, write, read, writedata, readdata, waitrequest); ctrl_data /
// ctrl_set control word and pulse; in_data/in_valid/in_ready input streams;
// out_data/out_set/out_waitrequest output streams.
// Optional macro MEM_IO_MAILBOX_IRQ_EN adds the irq port and IRQ_MASK register.
module mem_io_mailbox
  import mem_io_pkg::*;
#(
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned CTRL_W   = 32,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset_n,
  input  logic [ADDR_W-1:0]            avs_address,
  input  logic                         avs_write,
  input  logic                         avs_read,
  input  logic [DATA_W-1:0]            avs_writedata,
  output logic [DATA_W-1:0]            avs_readdata,
  output logic                         avs_waitrequest,
  output logic [CTRL_W-1:0]            ctrl_data,
  output logic                         ctrl_set,
  output logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic [CHANNELS-1:0]          in_valid,
  input  logic [CHANNELS-1:0]          in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   out_data,
  input  logic [CHANNELS-1:0]          out_set,
  output logic [CHANNELS-1:0]          out_waitrequest
`ifdef MEM_IO_MAILBOX_IRQ_EN
  ,
  output logic                         irq
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [CHANNELS-1:0] in_full, in_empty, out_full, out_empty;
  logic [CHANNELS-1:0] sel_hit, in_push, out_pop;
  logic [DATA_W-1:0]   in_head  [CHANNELS];
  logic [DATA_W-1:0]   out_head [CHANNELS];
  logic [CNT_W-1:0]    in_count_unused  [CHANNELS];
  logic [CNT_W-1:0]    out_count_unused [CHANNELS];

  logic [CHSEL_W-1:0]  chsel;
  logic                underflow;

  logic                wr_data_c, rd_data_c;
  logic                sel_in_full_c, sel_out_empty_c;
  logic [DATA_W-1:0]   sel_out_head_c, status_c, rdata_c;

`ifdef MEM_IO_MAILBOX_IRQ_EN
  logic [CHANNELS-1:0] irq_mask;
`endif

  assign wr_data_c = avs_write && (avs_address == ADDR_DATA);
  assign rd_data_c = avs_read  && (avs_address == ADDR_DATA);

  // Per-channel FIFO pair; selection is one-hot from CHSEL
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign sel_hit[g] = (chsel == CHSEL_W'(g));
    assign in_push[g] = wr_data_c & sel_hit[g];
    assign out_pop[g] = rd_data_c & sel_hit[g];

    mem_io_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
      .clk    (clk_clk),
      .rst_n  (reset_reset_n),
      .push   (in_push[g]),
      .wdata  (avs_writedata),
      .pop    (in_ready[g]),
      .head_c (in_head[g]),
      .full   (in_full[g]),
      .empty  (in_empty[g]),
      .count  (in_count_unused[g])
    );

    mem_io_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
      .clk    (clk_clk),
      .rst_n  (reset_reset_n),
      .push   (out_set[g]),
      .wdata  (out_data[g*DATA_W +: DATA_W]),
      .pop    (out_pop[g]),
      .head_c (out_head[g]),
      .full   (out_full[g]),
      .empty  (out_empty[g]),
      .count  (out_count_unused[g])
    );

    assign in_data[g*DATA_W +: DATA_W] = in_head[g];
  end

  assign in_valid        = ~in_empty;
  assign out_waitrequest = out_full;
  // Only a DATA write into a full input FIFO stalls; reads never do
  assign avs_waitrequest = wr_data_c & sel_in_full_c;

  // Selected-channel view; out_head is already zero when its FIFO is empty
  always_comb begin
    sel_in_full_c   = |(in_full & sel_hit);
    sel_out_empty_c = ~|(~out_empty & sel_hit);
    sel_out_head_c  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sel_hit[c]) sel_out_head_c = out_head[c];
    end
  end

  // STATUS word assembly
  always_comb begin
    status_c = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      status_c[status_full_bit(c)]     = in_full[c];
      status_c[status_nonempty_bit(c)] = ~out_empty[c];
    end
    status_c[UNDERFLOW_BIT] = underflow;
  end

  // Read data mux
  always_comb begin
    rdata_c = '0;
    case (avs_address)
      ADDR_STATUS:   rdata_c = status_c;
      ADDR_CHSEL:    rdata_c = DATA_W'(chsel);
      ADDR_DATA:     rdata_c = sel_out_head_c;
`ifdef MEM_IO_MAILBOX_IRQ_EN
      ADDR_IRQ_MASK: rdata_c = DATA_W'(irq_mask);
`endif
      default:       rdata_c = '0;
    endcase
  end

  // Register file, read pipeline and sticky underflow
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      ctrl_data    <= '0;
      ctrl_set     <= 1'b0;
      chsel        <= '0;
      underflow    <= 1'b0;
      avs_readdata <= '0;
    end else begin
      ctrl_set <= avs_write && (avs_address == ADDR_CONTROL);
      if (avs_write && (avs_address == ADDR_CONTROL))
        ctrl_data <= avs_writedata[CTRL_W-1:0];
      if (avs_write && (avs_address == ADDR_CHSEL))
        chsel <= (avs_writedata[CHSEL_W-1:0] >= CHSEL_W'(CHANNELS)) ?
                 CHSEL_W'(CHANNELS - 1) : avs_writedata[CHSEL_W-1:0];
      if (avs_read)
        avs_readdata <= rdata_c;
      // Underflow set wins; a STATUS read clears it after returning it
      if (rd_data_c && sel_out_empty_c)
        underflow <= 1'b1;
      else if (avs_read && (avs_address == ADDR_STATUS))
        underflow <= 1'b0;
    end
  end

`ifdef MEM_IO_MAILBOX_IRQ_EN
  // irq follows the registered non-empty flags one cycle later
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (avs_write && (avs_address == ADDR_IRQ_MASK))
        irq_mask <= avs_writedata[CHANNELS-1:0];
      irq <= |(irq_mask & ~out_empty);
    end
  end
`endif

endmodule

// File: tb/tb_mem_io_mailbox.sv
// Directed self-checking bench for mem_io_mailbox (default parameters).
// Define MEM_IO_MAILBOX_IRQ_EN on both DUT and bench to cover the irq path.
module tb_mem_io_mailbox;

  localparam int unsigned DATA_W   = 128;
  localparam int unsigned CTRL_W   = 32;
  localparam int unsigned CHANNELS = 2;
  localparam int unsigned DEPTH    = 16;

  localparam logic [2:0] A_CONTROL = 3'd0;
  localparam logic [2:0] A_STATUS  = 3'd1;
  localparam logic [2:0] A_CHSEL   = 3'd2;
  localparam logic [2:0] A_DATA    = 3'd3;
  localparam logic [2:0] A_IRQMASK = 3'd4;

  logic                       clk_clk = 1'b0;
  logic                       reset_reset_n;
  logic [2:0]                 avs_address;
  logic                       avs_write, avs_read;
  logic [DATA_W-1:0]          avs_writedata, avs_readdata;
  logic                       avs_waitrequest;
  logic [CTRL_W-1:0]          ctrl_data;
  logic                       ctrl_set;
  logic [CHANNELS*DATA_W-1:0] in_data, out_data;
  logic [CHANNELS-1:0]        in_valid, in_ready, out_set, out_waitrequest;
`ifdef MEM_IO_MAILBOX_IRQ_EN
  logic                       irq;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_clk = ~clk_clk;

  mem_io_mailbox #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CHANNELS(CHANNELS), .DEPTH(DEPTH)
  ) dut (
    .clk_clk         (clk_clk),
    .reset_reset_n   (reset_reset_n),
    .avs_address     (avs_address),
    .avs_write       (avs_write),
    .avs_read        (avs_read),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .avs_waitrequest (avs_waitrequest),
    .ctrl_data       (ctrl_data),
    .ctrl_set        (ctrl_set),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .out_data        (out_data),
    .out_set         (out_set),
    .out_waitrequest (out_waitrequest)
`ifdef MEM_IO_MAILBOX_IRQ_EN
    ,
    .irq             (irq)
`endif
  );

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Avalon write honouring waitrequest, bounded
  task automatic avs_wr(input logic [2:0] a, input logic [DATA_W-1:0] d);
    int n;
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    #1;
    n = 0;
    while (avs_waitrequest === 1'b1 && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) chk("wr_wait_bound", DATA_W'(avs_waitrequest), '0);
    tick();
    avs_write = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a,
                        input logic [DATA_W-1:0] exp);
    avs_address = a; avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
    chk(tag, avs_readdata, exp);
  endtask

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] e;

  initial begin
    reset_reset_n = 1'b0;
    avs_address = '0; avs_write = 1'b0; avs_read = 1'b0; avs_writedata = '0;
    in_ready = '0; out_set = '0; out_data = '0;
    tick(); tick();

    // Reset state
    chk("rst_ctrl_data", DATA_W'(ctrl_data), '0);
    chk("rst_ctrl_set", DATA_W'(ctrl_set), '0);
    chk("rst_readdata", avs_readdata, '0);
    chk("rst_waitreq", DATA_W'(avs_waitrequest), '0);
    chk("rst_in_valid", DATA_W'(in_valid), '0);
    chk("rst_in_data", DATA_W'(in_data), '0);
    chk("rst_out_waitreq", DATA_W'(out_waitrequest), '0);
    reset_reset_n = 1'b1;
    tick();

    // CONTROL write and one-cycle pulse
    avs_wr(A_CONTROL, 128'hDEADBEEF);
    chk("ctrl_data", DATA_W'(ctrl_data), 128'hDEADBEEF);
    chk("ctrl_set_hi", DATA_W'(ctrl_set), 128'h1);
    tick();
    chk("ctrl_set_lo", DATA_W'(ctrl_set), '0);
    rd_chk("status_idle", A_STATUS, '0);
    rd_chk("chsel_rst", A_CHSEL, '0);

    // Back-to-back CONTROL writes give back-to-back pulses
    avs_address = A_CONTROL; avs_writedata = 128'h1111; avs_write = 1'b1;
    tick();
    chk("b2b_set0", DATA_W'(ctrl_set), 128'h1);
    chk("b2b_data0", DATA_W'(ctrl_data), 128'h1111);
    avs_writedata = 128'h2222;
    tick();
    avs_write = 1'b0;
    chk("b2b_set1", DATA_W'(ctrl_set), 128'h1);
    chk("b2b_data1", DATA_W'(ctrl_data), 128'h2222);
    tick();
    chk("b2b_set_end", DATA_W'(ctrl_set), '0);

    // CHSEL clamp and readback
    avs_wr(A_CHSEL, 128'h9);
    rd_chk("chsel_clamp", A_CHSEL, 128'h1);
    avs_wr(A_CHSEL, 128'h0);
    rd_chk("chsel_0", A_CHSEL, 128'h0);
    avs_wr(A_CHSEL, 128'h1);

    // Fill input FIFO 1
    for (int i = 0; i < 16; i++) begin
      avs_wr(A_DATA, DATA_W'(32'h100 + i));
      if (i == 0) chk("in_valid_first", DATA_W'(in_valid), 128'h2);
    end
    chk("in_valid_full", DATA_W'(in_valid), 128'h2);
    chk("in_head_full", in_data[DATA_W +: DATA_W], 128'h100);
    rd_chk("status_in_full", A_STATUS, 128'h4);

    // 17th write stalls until one core pop
    avs_address = A_DATA; avs_writedata = 128'h200; avs_write = 1'b1;
    #1;
    chk("stall_wr_a", DATA_W'(avs_waitrequest), 128'h1);
    tick();
    chk("stall_wr_b", DATA_W'(avs_waitrequest), 128'h1);
    in_ready = 2'b10;
    tick();
    in_ready = 2'b00;
    chk("stall_release", DATA_W'(avs_waitrequest), '0);
    chk("head_after_pop", in_data[DATA_W +: DATA_W], 128'h101);
    tick();
    avs_write = 1'b0;
    for (int i = 1; i < 16; i++) begin
      chk("pop_order", in_data[DATA_W +: DATA_W], DATA_W'(32'h100 + i));
      in_ready = 2'b10; tick(); in_ready = 2'b00;
    end
    chk("pop_stalled_word", in_data[DATA_W +: DATA_W], 128'h200);
    in_ready = 2'b10; tick(); in_ready = 2'b00;
    chk("in_drained", DATA_W'(in_valid), '0);

    // Output FIFO 0 read and underflow
    out_data = '0; out_data[DATA_W-1:0] = 128'h42; out_set = 2'b01;
    tick();
    out_set = 2'b00;
    rd_chk("status_out0", A_STATUS, 128'h2);
    avs_wr(A_CHSEL, 128'h0);
    rd_chk("rd_out0", A_DATA, 128'h42);
    rd_chk("rd_underflow", A_DATA, '0);
    rd_chk("status_uf_set", A_STATUS, 128'h8000_0000);
    rd_chk("status_uf_clr", A_STATUS, '0);

    // Fill output FIFO 1, overflow push dropped
    for (int i = 0; i < 16; i++) begin
      out_data[DATA_W +: DATA_W] = DATA_W'(32'h300 + i); out_set = 2'b10;
      tick();
    end
    out_data[DATA_W +: DATA_W] = 128'h3FF;
    chk("out_wr_full", DATA_W'(out_waitrequest), 128'h2);
    tick();
    out_set = 2'b00;
    chk("out_wr_still", DATA_W'(out_waitrequest), 128'h2);
    rd_chk("status_out1_full", A_STATUS, 128'h8);
    avs_wr(A_CHSEL, 128'h1);
    for (int i = 0; i < 16; i++) rd_chk("rd_out1", A_DATA, DATA_W'(32'h300 + i));
    chk("out_wr_free", DATA_W'(out_waitrequest), '0);
    rd_chk("rd_dropped", A_DATA, '0);
    rd_chk("status_uf2", A_STATUS, 128'h8000_0000);

    // Concurrent push/pop on a half-full input FIFO
    q.delete();
    for (int i = 0; i < 8; i++) begin
      avs_wr(A_DATA, DATA_W'(32'h400 + i));
      q.push_back(DATA_W'(32'h400 + i));
    end
    for (int k = 0; k < 10; k++) begin
      avs_address = A_DATA; avs_writedata = DATA_W'(32'h500 + k);
      avs_write = 1'b1; in_ready = 2'b10;
      #1;
      chk("pp_waitreq", DATA_W'(avs_waitrequest), '0);
      chk("pp_head", in_data[DATA_W +: DATA_W], q[0]);
      tick();
      void'(q.pop_front());
      q.push_back(DATA_W'(32'h500 + k));
    end
    avs_write = 1'b0; in_ready = 2'b00;
    rd_chk("pp_status", A_STATUS, '0);
    for (int i = 0; i < 8; i++) begin
      e = q.pop_front();
      chk("pp_drain", in_data[DATA_W +: DATA_W], e);
      in_ready = 2'b10; tick(); in_ready = 2'b00;
    end
    chk("pp_empty", DATA_W'(in_valid), '0);

    // Reset mid-stream
    avs_wr(A_DATA, 128'hA1);
    avs_wr(A_DATA, 128'hA2);
    out_data[DATA_W-1:0] = 128'hB1; out_set = 2'b01;
    tick();
    out_set = 2'b00;
    avs_wr(A_CONTROL, 128'h55);
    rd_chk("pre_rst_status", A_STATUS, 128'h2);
    reset_reset_n = 1'b0;
    tick();
    chk("mid_rst_ctrl", DATA_W'(ctrl_data), '0);
    chk("mid_rst_rdata", avs_readdata, '0);
    chk("mid_rst_in_valid", DATA_W'(in_valid), '0);
    chk("mid_rst_in_data", DATA_W'(in_data), '0);
    chk("mid_rst_out_wr", DATA_W'(out_waitrequest), '0);
    reset_reset_n = 1'b1;
    tick();
    rd_chk("post_rst_status", A_STATUS, '0);
    rd_chk("post_rst_chsel", A_CHSEL, '0);

`ifdef MEM_IO_MAILBOX_IRQ_EN
    // IRQ masking and timing
    avs_wr(A_IRQMASK, 128'h2);
    rd_chk("irq_mask_rd", A_IRQMASK, 128'h2);
    out_data[DATA_W-1:0] = 128'hC0; out_set = 2'b01;
    tick();
    out_set = 2'b00;
    tick();
    chk("irq_masked", DATA_W'(irq), '0);
    out_data[DATA_W +: DATA_W] = 128'hC1; out_set = 2'b10;
    tick();
    out_set = 2'b00;
    chk("irq_not_yet", DATA_W'(irq), '0);
    tick();
    chk("irq_rise", DATA_W'(irq), 128'h1);
    avs_wr(A_CHSEL, 128'h1);
    rd_chk("irq_drain_rd", A_DATA, 128'hC1);
    tick();
    chk("irq_fall", DATA_W'(irq), '0);
`else
    avs_wr(A_IRQMASK, 128'hFF);
    rd_chk("addr4_zero", A_IRQMASK, '0);
`endif

    // Unmapped addresses
    avs_wr(3'd6, 128'hFFFF);
    rd_chk("addr5_zero", 3'd5, '0);
    rd_chk("addr6_zero", 3'd6, '0);
    rd_chk("addr7_zero", 3'd7, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
